// File: rtl/vga_timing_gen.sv
// VGA pixel timing: horizontal/vertical counters and phase FSMs advanced by clk_en, registered sync/blank/strobes.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit wrapping frame counter output.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_ACT_END  = 10'(H_DISPLAY - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_DISPLAY + H_FRONT - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_DISPLAY - 1);
    localparam logic [9:0] V_FP_END   = 10'(V_DISPLAY + V_FRONT - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    phase_t     h_phase, v_phase;
    phase_t     h_phase_nx, v_phase_nx;
    logic [9:0] hpos_nx, vpos_nx;
    logic       h_wrap, v_wrap;

    // Next-state is computed for the post-edge position so sync/blank land on the same edge as the counters.
    always_comb begin
        h_wrap     = (hpos == H_LAST);
        v_wrap     = (vpos == V_LAST);
        hpos_nx    = h_wrap ? '0 : hpos + 10'd1;
        vpos_nx    = vpos;
        h_phase_nx = h_phase;
        v_phase_nx = v_phase;

        if (h_wrap) begin
            h_phase_nx = PH_ACTIVE;
        end else begin
            case (h_phase)
                PH_ACTIVE: if (hpos == H_ACT_END)  h_phase_nx = PH_FRONT;
                PH_FRONT:  if (hpos == H_FP_END)   h_phase_nx = PH_SYNC;
                PH_SYNC:   if (hpos == H_SYNC_END) h_phase_nx = PH_BACK;
                default:   h_phase_nx = PH_BACK;
            endcase
        end

        if (h_wrap) begin
            vpos_nx = v_wrap ? '0 : vpos + 10'd1;
            if (v_wrap) begin
                v_phase_nx = PH_ACTIVE;
            end else begin
                case (v_phase)
                    PH_ACTIVE: if (vpos == V_ACT_END)  v_phase_nx = PH_FRONT;
                    PH_FRONT:  if (vpos == V_FP_END)   v_phase_nx = PH_SYNC;
                    PH_SYNC:   if (vpos == V_SYNC_END) v_phase_nx = PH_BACK;
                    default:   v_phase_nx = PH_BACK;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            h_phase     <= PH_BACK;
            v_phase     <= PH_BACK;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
            frame_count <= '0;
`endif
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (clk_en) begin
                hpos        <= hpos_nx;
                vpos        <= vpos_nx;
                h_phase     <= h_phase_nx;
                v_phase     <= v_phase_nx;
                hsync       <= (h_phase_nx == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
                vsync       <= (v_phase_nx == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
                display_on  <= (h_phase_nx == PH_ACTIVE) && (v_phase_nx == PH_ACTIVE);
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
`ifdef VGA_FRAME_COUNT_EN
                if (h_wrap && v_wrap) frame_count <= frame_count + 8'd1;
`endif
            end
        end
    end

endmodule
